uart_tx_sched: RTL and testbench
================================

// Module: uart_tx_sched
// PURPOSE
//  Shares one uart_tx serializer between NUM_REQ byte-stream requesters.
//  Round-robin arbitration with a per-port burst limit. Accepts a byte from the
//  winner and drives uart_tx through its valid/ready handshake. Waits for the
//  frame to finish, then inserts GAP_BITS idle bit-times before the next grant.
//  Sits between the host-side byte sources and uart_tx.
// PARAMETERS
//  NUM_REQ    4  number of requesters (>=2)
//  DATA_BITS  8  byte width; must match uart_tx DATA_BITS
//  MAX_BURST  4  max consecutive frames granted to one port (>=1; 1 = pure RR)
//  GAP_BITS   0  idle bit_ticks inserted after every frame (0..255)
// PORTS
//  clk        in   1                  single clock
//  rst        in   1                  reset, asynchronous, active-high
//  bit_tick   in   1                  1-cycle pulse per bit time (same as uart_tx)
//  req_valid  in   NUM_REQ            per-port byte available
//  req_data   in   NUM_REQ*DATA_BITS  port i byte at [i*DATA_BITS +: DATA_BITS]
//  req_ready  out  NUM_REQ            per-port accept; at most one bit high
//  tx_valid   out  1                  to uart_tx tx_valid
//  tx_data    out  DATA_BITS          to uart_tx tx_data
//  tx_ready   in   1                  from uart_tx tx_ready (high = idle)
//  grant_id   out  $clog2(NUM_REQ)    port owning current/last frame
//  busy       out  1                  high in any state but S_IDLE
// BEHAVIOUR
//  Interface: one clock; reset is asynchronous and active-high.
//  Reset values:
//   - tx_valid=0, tx_data=0, req_ready=0, grant_id=0, busy=0.
//   - last_ptr=NUM_REQ-1, so port 0 wins first; burst_cnt=0; state=S_IDLE.
//  Upstream handshake:
//   - A byte transfers on req_valid[i] & req_ready[i].
//   - req_valid and data must be held until the transfer.
//   - req_ready is combinational: high only in S_IDLE, only for the winner.
//  Winner selection (S_IDLE):
//   - If req_valid[last_ptr] and burst_cnt<MAX_BURST: last_ptr wins again.
//   - Otherwise: first valid port scanning last_ptr+1, +2, ... (mod NUM_REQ).
//  Burst counter:
//   - Same-port win -> burst_cnt+1.
//   - Different port -> burst_cnt=1, last_ptr=winner, grant_id=winner.
//  States:
//   - S_IDLE:
//     - no req_valid -> stay.
//     - else accept the winner's byte, register it into tx_data, set tx_valid=1,
//       go to S_SEND. The first tx_valid is one cycle after the accept.
//   - S_SEND:
//     - Hold tx_valid/tx_data stable until tx_valid & tx_ready.
//     - On that cycle: tx_valid<=0, go to S_WAIT.
//     - tx_ready low here (serializer busy) -> keep holding; never drop tx_valid.
//   - S_WAIT:
//     - Ignore tx_ready on the first cycle; uart_tx drops it one cycle after
//       the accept.
//     - From the second cycle, tx_ready==1 -> frame done.
//     - Frame done: GAP_BITS==0 -> S_IDLE, else gap_cnt=0 and go to S_GAP.
//   - S_GAP:
//     - gap_cnt+1 on each bit_tick.
//     - gap_cnt reaches GAP_BITS -> S_IDLE on that same cycle.
//  Throughput: one accept per frame.
//   - Accept to first tx_valid is 1 cycle.
//   - No second byte is taken while a frame is in flight.
//  Simultaneous events: req_valid changes during S_SEND/S_WAIT/S_GAP are ignored.
//   Only S_IDLE samples req_valid.
//  Dropped requesters:
//   - A requester that drops valid before grant simply loses the turn.
//   - last_ptr is unchanged by it.
//  Reset mid-frame: async clear to reset values. The in-flight byte is not
//   retried; uart_tx is reset on the same net.
// TESTING
//  1. Reset, then port0 valid data=8'hA5 -> req_ready[0] 1 cycle, tx_valid next
//     cycle with tx_data=A5, grant_id=0.
//  2. All 4 ports continuously valid, MAX_BURST=1 -> grant order 0,1,2,3,0,1.
//  3. Ports 1,2 continuously valid, MAX_BURST=4 -> 4 frames from port1, then
//     4 from port2, then port1.
//  4. tx_ready held low 20 cycles in S_SEND -> tx_valid/tx_data stable
//     throughout; exactly one accept.
//  5. GAP_BITS=3 -> exactly 3 bit_ticks between tx_ready rising and the next
//     req_ready pulse.
//  6. rst asserted mid-S_WAIT -> all outputs 0 the same cycle; after release,
//     port0 valid wins first.

Source files
------------

// File: rtl/uart_tx_sched_if.sv
// Handshake bundle between the byte requesters, the scheduler and uart_tx.
// Ports: bit_tick, req_valid/req_data/req_ready, tx_valid/tx_data/tx_ready, grant_id, busy.
interface uart_tx_sched_if #(
    parameter int NUM_REQ   = 4,
    parameter int DATA_BITS = 8
);
    localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    logic                           bit_tick;
    logic [NUM_REQ-1:0]             req_valid;
    logic [NUM_REQ*DATA_BITS-1:0]   req_data;
    logic [NUM_REQ-1:0]             req_ready;
    logic                           tx_valid;
    logic [DATA_BITS-1:0]           tx_data;
    logic                           tx_ready;
    logic [IW-1:0]                  grant_id;
    logic                           busy;

    modport master (
        input  bit_tick, req_valid, req_data, tx_ready,
        output req_ready, tx_valid, tx_data, grant_id, busy
    );

    modport slave (
        output bit_tick, req_valid, req_data, tx_ready,
        input  req_ready, tx_valid, tx_data, grant_id, busy
    );
endinterface

// File: rtl/uart_tx_sched.sv
// Shares one uart_tx between NUM_REQ byte requesters: round-robin with burst limit.
// Ports: clk, rst (async, active-high), bus (uart_tx_sched_if.master).
module uart_tx_sched #(
    parameter int NUM_REQ   = 4,
    parameter int DATA_BITS = 8,
    parameter int MAX_BURST = 4,
    parameter int GAP_BITS  = 0
) (
    input logic             clk,
    input logic             rst,
    uart_tx_sched_if.master bus
);
    localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int BW = $clog2(MAX_BURST + 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_SEND,
        S_WAIT,
        S_GAP
    } state_t;

    state_t               r_state;
    state_t               w_state_nxt;
    logic [IW-1:0]        r_last_ptr;
    logic [IW-1:0]        r_grant_id;
    logic [BW-1:0]        r_burst_cnt;
    logic [DATA_BITS-1:0] r_tx_data;
    logic                 r_tx_valid;
    logic                 r_wait_first;
    logic [7:0]           r_gap_cnt;

    logic                 w_any;
    logic                 w_repeat;
    logic [IW-1:0]        w_scan;
    logic                 w_scan_hit;
    logic [IW-1:0]        w_cand;
    logic [IW-1:0]        w_win;
    logic [DATA_BITS-1:0] w_win_data;
    logic                 w_gap_done;

    assign w_any = |bus.req_valid;

    // burst_cnt==0 means nothing granted since reset, so no port may
    // claim a repeat; that lets the scan start at port 0.
    assign w_repeat = bus.req_valid[r_last_ptr]
                   && (r_burst_cnt != '0)
                   && (r_burst_cnt < BW'(MAX_BURST));

    always_comb begin
        w_scan     = r_last_ptr;
        w_scan_hit = 1'b0;
        w_cand     = r_last_ptr;
        for (int k = 1; k <= NUM_REQ; k++) begin
            w_cand = IW'((int'(r_last_ptr) + k) % NUM_REQ);
            if (!w_scan_hit && bus.req_valid[w_cand]) begin
                w_scan     = w_cand;
                w_scan_hit = 1'b1;
            end
        end
    end

    assign w_win = w_repeat ? r_last_ptr : w_scan;

    always_comb begin
        w_win_data = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (w_win == IW'(i)) begin
                w_win_data = bus.req_data[i*DATA_BITS +: DATA_BITS];
            end
        end
    end

    // Gated by rst so every output is low while reset is held.
    always_comb begin
        bus.req_ready = '0;
        if (!rst && r_state == S_IDLE && w_any) begin
            bus.req_ready[w_win] = 1'b1;
        end
    end

    assign w_gap_done = bus.bit_tick
                     && (r_gap_cnt + 8'd1 == 8'(GAP_BITS));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            S_IDLE: begin
                if (w_any) w_state_nxt = S_SEND;
            end
            S_SEND: begin
                if (bus.tx_ready) w_state_nxt = S_WAIT;
            end
            S_WAIT: begin
                // uart_tx still shows ready on the cycle after its accept.
                if (!r_wait_first && bus.tx_ready) begin
                    w_state_nxt = (GAP_BITS == 0) ? S_IDLE : S_GAP;
                end
            end
            S_GAP: begin
                if (w_gap_done) w_state_nxt = S_IDLE;
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_last_ptr   <= IW'(NUM_REQ - 1);
            r_grant_id   <= '0;
            r_burst_cnt  <= '0;
            r_tx_data    <= '0;
            r_tx_valid   <= 1'b0;
            r_wait_first <= 1'b0;
            r_gap_cnt    <= '0;
        end else begin
            unique case (r_state)
                S_IDLE: begin
                    if (w_any) begin
                        r_tx_data   <= w_win_data;
                        r_tx_valid  <= 1'b1;
                        r_last_ptr  <= w_win;
                        r_grant_id  <= w_win;
                        r_burst_cnt <= w_repeat ? r_burst_cnt + BW'(1) : BW'(1);
                    end
                end
                S_SEND: begin
                    if (bus.tx_ready) begin
                        r_tx_valid   <= 1'b0;
                        r_wait_first <= 1'b1;
                    end
                end
                S_WAIT: begin
                    r_wait_first <= 1'b0;
                    r_gap_cnt    <= '0;
                end
                S_GAP: begin
                    if (bus.bit_tick) r_gap_cnt <= r_gap_cnt + 8'd1;
                end
                default: ;
            endcase
        end
    end

    assign bus.tx_valid = r_tx_valid;
    assign bus.tx_data  = r_tx_data;
    assign bus.grant_id = r_grant_id;
    assign bus.busy     = (r_state != S_IDLE);
endmodule

// File: tb/tb_uart_tx_sched.sv
// Bench for uart_tx_sched: two instances (pure RR; burst 4 with 3-bit gap).
// Each instance talks to a small uart_tx model; a queue holds expected frames.
module tb_uart_tx_sched;
    localparam int NR    = 4;
    localparam int DW    = 8;
    localparam int FRAME = 10;

    typedef struct {
        int         port;
        logic [7:0] data;
    } exp_t;

    logic clk = 1'b0;
    logic rst;
    logic tick;
    logic [1:0] tcnt;
    logic hold_b;
    int n_vec = 0;
    int n_mis = 0;
    exp_t q[$];

    logic a_rdy, a_pend, b_rdy, b_pend;
    int a_cnt, b_cnt;
    int sa[NR];
    int sb[NR];

    uart_tx_sched_if #(.NUM_REQ(NR), .DATA_BITS(DW)) ifa ();
    uart_tx_sched_if #(.NUM_REQ(NR), .DATA_BITS(DW)) ifb ();

    uart_tx_sched #(.NUM_REQ(NR), .DATA_BITS(DW), .MAX_BURST(1), .GAP_BITS(0))
        u_rr (.clk(clk), .rst(rst), .bus(ifa.master));

    uart_tx_sched #(.NUM_REQ(NR), .DATA_BITS(DW), .MAX_BURST(4), .GAP_BITS(3))
        u_main (.clk(clk), .rst(rst), .bus(ifb.master));

    always #5 clk = ~clk;

    function automatic logic [7:0] dat(input int p, input int n);
        logic [7:0] b;
        case (p)
            0: b = 8'hA5;
            1: b = 8'h3C;
            2: b = 8'h5A;
            default: b = 8'hC3;
        endcase
        return b + 8'(n * 17);
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            tcnt <= 2'd0;
            tick <= 1'b0;
        end else begin
            tcnt <= tcnt + 2'd1;
            tick <= (tcnt == 2'd3);
        end
    end

    assign ifa.bit_tick = tick;
    assign ifb.bit_tick = tick;
    assign ifa.tx_ready = a_rdy;
    assign ifb.tx_ready = b_rdy & ~hold_b;

    // uart_tx model: drops ready one cycle after accept, busy FRAME cycles
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            a_rdy <= 1'b1; a_pend <= 1'b0; a_cnt <= 0;
        end else if (a_pend) begin
            a_pend <= 1'b0; a_rdy <= 1'b0; a_cnt <= FRAME;
        end else if (!a_rdy) begin
            if (a_cnt == 0) a_rdy <= 1'b1;
            else a_cnt <= a_cnt - 1;
        end else if (ifa.tx_valid) begin
            a_pend <= 1'b1;
        end
    end

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            b_rdy <= 1'b1; b_pend <= 1'b0; b_cnt <= 0;
        end else if (b_pend) begin
            b_pend <= 1'b0; b_rdy <= 1'b0; b_cnt <= FRAME;
        end else if (!b_rdy) begin
            if (b_cnt == 0) b_rdy <= 1'b1;
            else b_cnt <= b_cnt - 1;
        end else if (ifb.tx_valid && !hold_b) begin
            b_pend <= 1'b1;
        end
    end

    // per-port byte sequence advances only after a transfer
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NR; i++) begin
                sa[i] <= 0;
                sb[i] <= 0;
            end
        end else begin
            for (int i = 0; i < NR; i++) begin
                if (ifa.req_valid[i] && ifa.req_ready[i]) sa[i] <= sa[i] + 1;
                if (ifb.req_valid[i] && ifb.req_ready[i]) sb[i] <= sb[i] + 1;
            end
        end
    end

    for (genvar g = 0; g < NR; g++) begin : g_data
        assign ifa.req_data[g*DW +: DW] = dat(g, sa[g]);
        assign ifb.req_data[g*DW +: DW] = dat(g, sb[g]);
    end

    task automatic do_reset();
        rst = 1'b1;
        ifa.req_valid = '0;
        ifb.req_valid = '0;
        hold_b = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        q.delete();
    endtask

    task automatic test_reset();
        rst = 1'b1;
        ifa.req_valid = '0;
        ifb.req_valid = '0;
        hold_b = 1'b0;
        @(negedge clk);
        #1;
        n_vec++; if (ifb.tx_valid !== 1'b0) begin n_mis++; $display("FAIL rst_tx_valid got=%b exp=0", ifb.tx_valid); end
        n_vec++; if (ifb.tx_data !== 8'h00) begin n_mis++; $display("FAIL rst_tx_data got=%h exp=00", ifb.tx_data); end
        n_vec++; if (ifb.req_ready !== 4'b0) begin n_mis++; $display("FAIL rst_req_ready got=%b exp=0000", ifb.req_ready); end
        n_vec++; if (ifb.grant_id !== 2'd0) begin n_mis++; $display("FAIL rst_grant_id got=%0d exp=0", ifb.grant_id); end
        n_vec++; if (ifb.busy !== 1'b0) begin n_mis++; $display("FAIL rst_busy got=%b exp=0", ifb.busy); end
        n_vec++; if (ifa.tx_valid !== 1'b0 || ifa.busy !== 1'b0) begin n_mis++; $display("FAIL rst_rr got=%b%b exp=00", ifa.tx_valid, ifa.busy); end
        rst = 1'b0;
        @(negedge clk);
        #1;
        n_vec++; if (ifb.busy !== 1'b0 || ifb.tx_valid !== 1'b0) begin n_mis++; $display("FAIL post_rst_idle got=%b%b exp=00", ifb.busy, ifb.tx_valid); end
    endtask

    task automatic test_single();
        bit done;
        do_reset();
        ifb.req_valid = 4'b0001;
        #1;
        n_vec++; if (ifb.req_ready !== 4'b0001) begin n_mis++; $display("FAIL single_ready got=%b exp=0001", ifb.req_ready); end
        n_vec++; if (ifb.tx_valid !== 1'b0) begin n_mis++; $display("FAIL single_early_valid got=%b exp=0", ifb.tx_valid); end
        @(negedge clk);
        #1;
        ifb.req_valid = 4'b0000;
        n_vec++; if (ifb.tx_valid !== 1'b1) begin n_mis++; $display("FAIL single_tx_valid got=%b exp=1", ifb.tx_valid); end
        n_vec++; if (ifb.tx_data !== 8'hA5) begin n_mis++; $display("FAIL single_tx_data got=%h exp=a5", ifb.tx_data); end
        n_vec++; if (ifb.grant_id !== 2'd0) begin n_mis++; $display("FAIL single_grant got=%0d exp=0", ifb.grant_id); end
        n_vec++; if (ifb.busy !== 1'b1) begin n_mis++; $display("FAIL single_busy got=%b exp=1", ifb.busy); end
        done = 1'b0;
        for (int c = 0; c < 200 && !done; c++) begin
            @(negedge clk);
            #1;
            if (!ifb.busy) done = 1'b1;
        end
        n_vec++; if (!done) begin n_mis++; $display("FAIL single_finish got=busy exp=idle"); end
    endtask

    task automatic test_rr();
        int ord[6] = '{0, 1, 2, 3, 0, 1};
        int cnt[NR] = '{default: 0};
        exp_t e;
        do_reset();
        foreach (ord[k]) begin
            e.port = ord[k];
            e.data = dat(ord[k], cnt[ord[k]]);
            cnt[ord[k]]++;
            q.push_back(e);
        end
        ifa.req_valid = 4'b1111;
        for (int c = 0; c < 600 && q.size() > 0; c++) begin
            #1;
            if (ifa.tx_valid && ifa.tx_ready) begin
                e = q.pop_front();
                n_vec++;
                if (ifa.tx_data !== e.data || ifa.grant_id !== 2'(e.port)) begin
                    n_mis++;
                    $display("FAIL rr_frame got=p%0d/%h exp=p%0d/%h", ifa.grant_id, ifa.tx_data, e.port, e.data);
                end
            end
            @(negedge clk);
        end
        n_vec++; if (q.size() != 0) begin n_mis++; $display("FAIL rr_timeout got=%0d left exp=0", q.size()); end
        ifa.req_valid = 4'b0000;
    endtask

    task automatic test_burst();
        int ord[9] = '{1, 1, 1, 1, 2, 2, 2, 2, 1};
        int cnt[NR] = '{default: 0};
        exp_t e;
        do_reset();
        foreach (ord[k]) begin
            e.port = ord[k];
            e.data = dat(ord[k], cnt[ord[k]]);
            cnt[ord[k]]++;
            q.push_back(e);
        end
        ifb.req_valid = 4'b0110;
        for (int c = 0; c < 1500 && q.size() > 0; c++) begin
            #1;
            if (ifb.tx_valid && ifb.tx_ready) begin
                e = q.pop_front();
                n_vec++;
                if (ifb.tx_data !== e.data || ifb.grant_id !== 2'(e.port)) begin
                    n_mis++;
                    $display("FAIL burst_frame got=p%0d/%h exp=p%0d/%h", ifb.grant_id, ifb.tx_data, e.port, e.data);
                end
            end
            @(negedge clk);
        end
        n_vec++; if (q.size() != 0) begin n_mis++; $display("FAIL burst_timeout got=%0d left exp=0", q.size()); end
        ifb.req_valid = 4'b0000;
    endtask

    task automatic test_stall();
        int acc;
        exp_t e;
        do_reset();
        hold_b = 1'b1;
        ifb.req_valid = 4'b0001;
        e.port = 0;
        e.data = dat(0, 0);
        q.push_back(e);
        acc = 0;
        for (int c = 0; c < 22; c++) begin
            #1;
            if ((ifb.req_valid & ifb.req_ready) != 4'b0) acc++;
            if (c >= 1) begin
                n_vec++;
                if (ifb.tx_valid !== 1'b1 || ifb.tx_data !== e.data) begin
                    n_mis++;
                    $display("FAIL stall_hold c=%0d got=%b/%h exp=1/%h", c, ifb.tx_valid, ifb.tx_data, e.data);
                end
            end
            @(negedge clk);
        end
        n_vec++; if (acc != 1) begin n_mis++; $display("FAIL stall_accepts got=%0d exp=1", acc); end
        ifb.req_valid = 4'b0000;
        hold_b = 1'b0;
        for (int c = 0; c < 100 && q.size() > 0; c++) begin
            #1;
            if (ifb.tx_valid && ifb.tx_ready) begin
                e = q.pop_front();
                n_vec++;
                if (ifb.tx_data !== e.data) begin
                    n_mis++;
                    $display("FAIL stall_frame got=%h exp=%h", ifb.tx_data, e.data);
                end
            end
            @(negedge clk);
        end
        n_vec++; if (q.size() != 0) begin n_mis++; $display("FAIL stall_timeout got=%0d left exp=0", q.size()); end
    endtask

    task automatic test_gap();
        int ph;
        int ticks;
        bit done;
        do_reset();
        ifb.req_valid = 4'b0001;
        ph = 0;
        ticks = 0;
        done = 1'b0;
        for (int c = 0; c < 300 && !done; c++) begin
            #1;
            case (ph)
                0: if (!ifb.tx_ready) ph = 1;
                1: if (ifb.tx_ready) ph = 2;
                default: begin
                    if (ifb.req_ready != 4'b0) done = 1'b1;
                    else if (tick) ticks++;
                end
            endcase
            if (!done) @(negedge clk);
        end
        n_vec++; if (!done) begin n_mis++; $display("FAIL gap_timeout got=phase%0d exp=regrant", ph); end
        n_vec++; if (ticks != 3) begin n_mis++; $display("FAIL gap_ticks got=%0d exp=3", ticks); end
        n_vec++; if (ifb.req_ready !== 4'b0001) begin n_mis++; $display("FAIL gap_regrant got=%b exp=0001", ifb.req_ready); end
        @(negedge clk);
        ifb.req_valid = 4'b0000;
    endtask

    task automatic test_mid_reset();
        bit seen;
        do_reset();
        ifb.req_valid = 4'b0010;
        seen = 1'b0;
        for (int c = 0; c < 50 && !seen; c++) begin
            #1;
            if (ifb.tx_valid && ifb.tx_ready) seen = 1'b1;
            @(negedge clk);
        end
        n_vec++; if (!seen) begin n_mis++; $display("FAIL mid_no_frame got=none exp=accept"); end
        @(negedge clk);
        #1;
        n_vec++; if (ifb.grant_id !== 2'd1 || ifb.busy !== 1'b1) begin n_mis++; $display("FAIL mid_pre got=%0d/%b exp=1/1", ifb.grant_id, ifb.busy); end
        rst = 1'b1;
        ifb.req_valid = 4'b0011;
        #1;
        n_vec++; if (ifb.tx_valid !== 1'b0) begin n_mis++; $display("FAIL mid_tx_valid got=%b exp=0", ifb.tx_valid); end
        n_vec++; if (ifb.tx_data !== 8'h00) begin n_mis++; $display("FAIL mid_tx_data got=%h exp=00", ifb.tx_data); end
        n_vec++; if (ifb.req_ready !== 4'b0) begin n_mis++; $display("FAIL mid_req_ready got=%b exp=0000", ifb.req_ready); end
        n_vec++; if (ifb.grant_id !== 2'd0) begin n_mis++; $display("FAIL mid_grant got=%0d exp=0", ifb.grant_id); end
        n_vec++; if (ifb.busy !== 1'b0) begin n_mis++; $display("FAIL mid_busy got=%b exp=0", ifb.busy); end
        @(negedge clk);
        rst = 1'b0;
        #1;
        n_vec++; if (ifb.req_ready !== 4'b0001) begin n_mis++; $display("FAIL mid_first_win got=%b exp=0001", ifb.req_ready); end
        @(negedge clk);
        ifb.req_valid = 4'b0000;
    endtask

    initial begin
        rst = 1'b1;
        hold_b = 1'b0;
        ifa.req_valid = '0;
        ifb.req_valid = '0;
        test_reset();
        test_single();
        test_rr();
        test_burst();
        test_stall();
        test_gap();
        test_mid_reset();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
        $finish;
    end
endmodule
